// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding a one-bit serial consumer.
// One word sits in the shifter and a second can wait in a hold register,
// so back-to-back words stream out with no idle gap between frames.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             accept;
    logic             load_en;
    logic [WIDTH-1:0] load_word;

    // Bit that leaves the word first, given the configured order.
    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit consumed.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_ready = !hold_full_q && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != StIdle) || hold_full_q;

    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign frame_done = frame_done_q;

    // Next-state: route accepted words, advance the shifter, refill at frame end.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        frame_done_d = 1'b0;
        load_en      = 1'b0;
        load_word    = in_data;

        unique case (state_q)
            StIdle: begin
                sout_d       = IDLE_BIT;
                sout_valid_d = 1'b0;
                if (accept) begin
                    load_en = 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == LastCnt) begin
                    // Last bit on the line: refill from hold first, else take a
                    // fresh word directly, else drop back to idle.
                    if (hold_full_q) begin
                        load_en     = 1'b1;
                        load_word   = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load_en = 1'b1;
                    end else begin
                        state_d      = StIdle;
                        sout_d       = IDLE_BIT;
                        sout_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d        = cnt_q + 1'b1;
                    sout_d       = next_bit(shift_q);
                    shift_d      = shift_once(shift_q);
                    frame_done_d = (cnt_d == LastCnt);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // First bit of a newly loaded word goes out in the very next cycle.
        if (load_en) begin
            state_d      = StShift;
            cnt_d        = '0;
            sout_d       = next_bit(load_word);
            shift_d      = shift_once(load_word);
            sout_valid_d = 1'b1;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
